// File: rtl/dm_arbiter_if.sv
// dm_arbiter_if: bundles the CPU port, display burst port and the shared
// data-memory port of the arbiter.
//   slave  : arbiter view (requests and memory read data in, grants/memory
//            controls out)
//   master : environment view (CPU, display engine and memory model)
interface dm_arbiter_if;
  localparam int unsigned AW = 13;
  localparam int unsigned DW = 16;

  // CPU port
  logic [AW-1:0] cpu_addr;
  logic          cpu_re;
  logic          cpu_we;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic          cpu_stall;
  logic [DW-1:0] cpu_rdata;

  // Display burst port
  logic          disp_req;
  logic [AW-1:0] disp_base;
  logic          disp_busy;
  logic          disp_rvalid;
  logic [DW-1:0] disp_rdata;
  logic          disp_done;

  // Shared data-memory port
  logic [AW-1:0] dm_addr;
  logic          dm_re;
  logic          dm_we;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rd_data;

  modport slave (
    input  cpu_addr, cpu_re, cpu_we, cpu_wdata,
    output cpu_gnt, cpu_stall, cpu_rdata,
    input  disp_req, disp_base,
    output disp_busy, disp_rvalid, disp_rdata, disp_done,
    output dm_addr, dm_re, dm_we, dm_wdata,
    input  dm_rd_data
  );

  modport master (
    output cpu_addr, cpu_re, cpu_we, cpu_wdata,
    input  cpu_gnt, cpu_stall, cpu_rdata,
    output disp_req, disp_base,
    input  disp_busy, disp_rvalid, disp_rdata, disp_done,
    input  dm_addr, dm_re, dm_we, dm_wdata,
    output dm_rd_data
  );
endinterface

// File: rtl/dm_arbiter.sv
// dm_arbiter: single-port data-memory arbiter between a CPU and a display
// burst reader. One winner per cycle, chosen combinationally; the memory
// acts on the negedge, so CPU reads return data within the same cycle.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : dm_arbiter_if.slave (CPU, display and memory signals)
// Parameters:
//   BURST_LEN  : display words per burst (1..256)
//   STARVE_LIM : consecutive CPU wins in a burst before the display is forced
module dm_arbiter #(
  parameter int unsigned BURST_LEN  = 8,
  parameter int unsigned STARVE_LIM = 3
) (
  input logic          clk,
  input logic          rst_n,
  dm_arbiter_if.slave  bus
);

  localparam int unsigned AW = 13;
  localparam int unsigned DW = 16;
  localparam int unsigned BW = 9;
  localparam int unsigned SW = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] baddr_q, baddr_d;
  logic [BW-1:0] beat_q,  beat_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          busy_q,  busy_d;
  logic          done_q,  done_d;

  logic cpu_req;
  logic cpu_win;
  logic disp_win;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      baddr_q  <= '0;
      beat_q   <= '0;
      starve_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baddr_q  <= baddr_d;
      beat_q   <= beat_d;
      starve_q <= starve_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Winner selection and next-state logic
  always_comb begin
    state_d  = state_q;
    baddr_d  = baddr_q;
    beat_d   = beat_q;
    starve_d = starve_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    cpu_win  = 1'b0;
    disp_win = 1'b0;
    cpu_req  = bus.cpu_re | bus.cpu_we;

    case (state_q)
      IDLE: begin
        cpu_win = cpu_req;
        if (bus.disp_req) begin
          state_d  = BURST;
          baddr_d  = bus.disp_base;
          beat_d   = '0;
          starve_d = '0;
          busy_d   = 1'b1;
        end
      end
      BURST: begin
        disp_win = !cpu_req || (starve_q == SW'(STARVE_LIM));
        cpu_win  = !disp_win;
        if (disp_win) begin
          // 13-bit address wraps naturally from 8191 to 0
          baddr_d  = baddr_q + AW'(1);
          beat_d   = beat_q + BW'(1);
          starve_d = '0;
          if (beat_q == BW'(BURST_LEN - 1)) begin
            state_d  = IDLE;
            busy_d   = 1'b0;
            done_d   = 1'b1;
          end
        end else begin
          starve_d = starve_q + SW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Grants are combinational from requests, so hold them off during reset
    if (!rst_n) begin
      cpu_win  = 1'b0;
      disp_win = 1'b0;
    end
  end

  // Memory port driven from the winner; write beats read on a dual request
  always_comb begin
    bus.dm_addr  = '0;
    bus.dm_re    = 1'b0;
    bus.dm_we    = 1'b0;
    bus.dm_wdata = '0;
    if (cpu_win) begin
      bus.dm_addr = bus.cpu_addr;
      if (bus.cpu_we) begin
        bus.dm_we    = 1'b1;
        bus.dm_wdata = bus.cpu_wdata;
      end else begin
        bus.dm_re = 1'b1;
      end
    end else if (disp_win) begin
      bus.dm_addr = baddr_q;
      bus.dm_re   = 1'b1;
    end
  end

  // Client-side outputs
  always_comb begin
    bus.cpu_gnt     = cpu_win;
    bus.cpu_stall   = cpu_req && !cpu_win && rst_n;
    bus.cpu_rdata   = DW'(bus.dm_rd_data);
    bus.disp_rvalid = disp_win;
    bus.disp_rdata  = DW'(bus.dm_rd_data);
    bus.disp_busy   = busy_q;
    bus.disp_done   = done_q;
  end

  // Memory must never see a read and a write together
  a_excl_rw: assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.dm_re && bus.dm_we));

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed, table-driven bench for dm_arbiter with a
// negedge-acting memory model. A second instance with BURST_LEN=4 covers
// the address wrap case.
module tb_dm_arbiter;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  dm_arbiter_if b8 ();
  dm_arbiter_if b4 ();

  dm_arbiter #(.BURST_LEN(8), .STARVE_LIM(3)) u8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));
  dm_arbiter #(.BURST_LEN(4), .STARVE_LIM(3)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] mem [8192];

  function automatic logic [15:0] pat(input logic [12:0] a);
    return 16'(a) ^ 16'hA5A5;
  endfunction

  // Memory models act on the negedge
  always @(negedge clk) begin
    if (b8.dm_we) mem[b8.dm_addr] <= b8.dm_wdata;
    if (b8.dm_re) b8.dm_rd_data <= mem[b8.dm_addr];
  end
  always @(negedge clk) begin
    if (b4.dm_re) b4.dm_rd_data <= pat(b4.dm_addr);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Start of a cycle: wait posedge, drive inputs, settle
  task automatic step_in(input logic re, input logic we, input logic [12:0] addr,
                         input logic [15:0] wd, input logic dreq, input logic [12:0] dbase);
    @(posedge clk);
    #1;
    b8.cpu_re    = re;
    b8.cpu_we    = we;
    b8.cpu_addr  = addr;
    b8.cpu_wdata = wd;
    b8.disp_req  = dreq;
    b8.disp_base = dbase;
    #1;
  endtask

  task automatic end_cyc();
    @(negedge clk);
    #1;
  endtask

  typedef struct {
    logic        re, we;
    logic [12:0] addr;
    logic [15:0] wdata;
    logic        dreq;
    logic [12:0] dbase;
    logic        gnt, stall, rv, busy, done, dre, dwe;
    logic [12:0] daddr;
    logic        ck_rd;
    logic [15:0] rd;
  } vec_t;

  function automatic vec_t mk(input logic re, input logic we, input logic [12:0] addr,
                              input logic [15:0] wd, input logic dreq, input logic [12:0] dbase,
                              input logic gnt, input logic stall, input logic rv,
                              input logic busy, input logic done, input logic dre,
                              input logic dwe, input logic [12:0] daddr,
                              input logic ck_rd, input logic [15:0] rd);
    vec_t v;
    v.re = re; v.we = we; v.addr = addr; v.wdata = wd; v.dreq = dreq; v.dbase = dbase;
    v.gnt = gnt; v.stall = stall; v.rv = rv; v.busy = busy; v.done = done;
    v.dre = dre; v.dwe = dwe; v.daddr = daddr; v.ck_rd = ck_rd; v.rd = rd;
    return v;
  endfunction

  vec_t vecs [16];

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 8192; i++) mem[i] = pat(13'(i));
    b8.cpu_re = 1'b1; b8.cpu_we = 1'b0; b8.cpu_addr = 13'h0040; b8.cpu_wdata = '0;
    b8.disp_req = 1'b1; b8.disp_base = 13'h0100; b8.dm_rd_data = '0;
    b4.cpu_re = 1'b0; b4.cpu_we = 1'b0; b4.cpu_addr = '0; b4.cpu_wdata = '0;
    b4.disp_req = 1'b0; b4.disp_base = '0; b4.dm_rd_data = '0;
    rst_n = 1'b0;

    // Reset state with requests present
    #7;
    chk("rst_gnt",   32'(b8.cpu_gnt),     0);
    chk("rst_stall", 32'(b8.cpu_stall),   0);
    chk("rst_rv",    32'(b8.disp_rvalid), 0);
    chk("rst_busy",  32'(b8.disp_busy),   0);
    chk("rst_done",  32'(b8.disp_done),   0);
    chk("rst_dmre",  32'(b8.dm_re),       0);
    chk("rst_dmwe",  32'(b8.dm_we),       0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    b8.cpu_re = 1'b0; b8.disp_req = 1'b0;

    //            re we addr     wdata    dreq base     gnt st rv by dn dre dwe daddr    ck rd
    vecs[0]  = mk(0, 0, 13'h0000, 16'h0000, 0, 13'h0000, 0, 0, 0, 0, 0, 0, 0, 13'h0000, 0, 16'h0000);
    vecs[1]  = mk(0, 1, 13'h0040, 16'h1234, 0, 13'h0000, 1, 0, 0, 0, 0, 0, 1, 13'h0040, 0, 16'h0000);
    vecs[2]  = mk(1, 0, 13'h0040, 16'h0000, 0, 13'h0000, 1, 0, 0, 0, 0, 1, 0, 13'h0040, 1, 16'h1234);
    vecs[3]  = mk(1, 1, 13'h0041, 16'hBEEF, 0, 13'h0000, 1, 0, 0, 0, 0, 0, 1, 13'h0041, 0, 16'h0000);
    vecs[4]  = mk(1, 0, 13'h0041, 16'h0000, 0, 13'h0000, 1, 0, 0, 0, 0, 1, 0, 13'h0041, 1, 16'hBEEF);
    vecs[5]  = mk(0, 0, 13'h0000, 16'h0000, 1, 13'h0100, 0, 0, 0, 0, 0, 0, 0, 13'h0000, 0, 16'h0000);
    for (int i = 0; i < 8; i++)
      vecs[6+i] = mk(0, 0, 13'h0000, 16'h0000, (i == 0), 13'h0200, 0, 0, 1, 1, 0, 1, 0,
                     13'h0100 + 13'(i), 1, pat(13'h0100 + 13'(i)));
    vecs[14] = mk(0, 0, 13'h0000, 16'h0000, 0, 13'h0000, 0, 0, 0, 0, 1, 0, 0, 13'h0000, 0, 16'h0000);
    vecs[15] = mk(0, 0, 13'h0000, 16'h0000, 0, 13'h0000, 0, 0, 0, 0, 0, 0, 0, 13'h0000, 0, 16'h0000);

    foreach (vecs[i]) begin
      step_in(vecs[i].re, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].dreq, vecs[i].dbase);
      chk($sformatf("v%0d_gnt", i),   32'(b8.cpu_gnt),     32'(vecs[i].gnt));
      chk($sformatf("v%0d_stall", i), 32'(b8.cpu_stall),   32'(vecs[i].stall));
      chk($sformatf("v%0d_rv", i),    32'(b8.disp_rvalid), 32'(vecs[i].rv));
      chk($sformatf("v%0d_busy", i),  32'(b8.disp_busy),   32'(vecs[i].busy));
      chk($sformatf("v%0d_done", i),  32'(b8.disp_done),   32'(vecs[i].done));
      chk($sformatf("v%0d_dmre", i),  32'(b8.dm_re),       32'(vecs[i].dre));
      chk($sformatf("v%0d_dmwe", i),  32'(b8.dm_we),       32'(vecs[i].dwe));
      chk($sformatf("v%0d_addr", i),  32'(b8.dm_addr),     32'(vecs[i].daddr));
      end_cyc();
      if (vecs[i].ck_rd) begin
        chk($sformatf("v%0d_crd", i), 32'(b8.cpu_rdata),  32'(vecs[i].rd));
        chk($sformatf("v%0d_drd", i), 32'(b8.disp_rdata), 32'(vecs[i].rd));
      end
    end

    // disp_req held high restarts right after done with the newly sampled base
    step_in(0, 0, 0, 0, 1, 13'h0300);
    end_cyc();
    for (int i = 0; i < 8; i++) begin
      step_in(0, 0, 0, 0, 1, 13'h0300);
      chk($sformatf("hold_b%0d_rv", i),   32'(b8.disp_rvalid), 1);
      chk($sformatf("hold_b%0d_addr", i), 32'(b8.dm_addr),     32'(13'h0300 + 13'(i)));
      end_cyc();
    end
    step_in(0, 0, 0, 0, 1, 13'h0400);
    chk("hold_done",  32'(b8.disp_done), 1);
    chk("hold_dbusy", 32'(b8.disp_busy), 0);
    end_cyc();
    for (int i = 0; i < 8; i++) begin
      step_in(0, 0, 0, 0, 0, 13'h0000);
      chk($sformatf("re_b%0d_busy", i), 32'(b8.disp_busy), 1);
      chk($sformatf("re_b%0d_addr", i), 32'(b8.dm_addr),   32'(13'h0400 + 13'(i)));
      end_cyc();
    end
    step_in(0, 0, 0, 0, 0, 13'h0000);
    chk("re_done", 32'(b8.disp_done), 1);
    end_cyc();

    // CPU reads every cycle: 3 CPU wins then one forced display beat
    step_in(1, 0, 13'h0040, 0, 1, 13'h0500);
    chk("st_idle_gnt", 32'(b8.cpu_gnt), 1);
    end_cyc();
    for (int k = 0; k < 32; k++) begin
      logic dw;
      logic [12:0] ba;
      dw = ((k % 4) == 3);
      ba = 13'h0500 + 13'(k / 4);
      step_in(1, 0, 13'h0040, 0, 0, 13'h0000);
      chk($sformatf("st%0d_gnt", k),   32'(b8.cpu_gnt),     32'(!dw));
      chk($sformatf("st%0d_stall", k), 32'(b8.cpu_stall),   32'(dw));
      chk($sformatf("st%0d_rv", k),    32'(b8.disp_rvalid), 32'(dw));
      chk($sformatf("st%0d_addr", k),  32'(b8.dm_addr),     dw ? 32'(ba) : 32'h0040);
      end_cyc();
      chk($sformatf("st%0d_rd", k), 32'(b8.cpu_rdata), dw ? 32'(pat(ba)) : 32'h1234);
    end
    step_in(1, 0, 13'h0040, 0, 0, 13'h0000);
    chk("st_done", 32'(b8.disp_done), 1);
    chk("st_gnt",  32'(b8.cpu_gnt),   1);
    end_cyc();

    // Reset after three beats abandons the burst
    step_in(0, 0, 0, 0, 1, 13'h0600);
    end_cyc();
    for (int i = 0; i < 3; i++) begin
      step_in(0, 0, 0, 0, 0, 13'h0000);
      chk($sformatf("rb%0d_addr", i), 32'(b8.dm_addr), 32'(13'h0600 + 13'(i)));
      end_cyc();
    end
    step_in(1, 0, 13'h0040, 0, 1, 13'h0600);
    rst_n = 1'b0;
    #1;
    chk("mr_gnt",   32'(b8.cpu_gnt),     0);
    chk("mr_stall", 32'(b8.cpu_stall),   0);
    chk("mr_rv",    32'(b8.disp_rvalid), 0);
    chk("mr_busy",  32'(b8.disp_busy),   0);
    chk("mr_done",  32'(b8.disp_done),   0);
    chk("mr_dmre",  32'(b8.dm_re),       0);
    chk("mr_dmwe",  32'(b8.dm_we),       0);
    chk("mr_addr",  32'(b8.dm_addr),     0);
    end_cyc();
    step_in(0, 0, 0, 0, 1, 13'h0700);
    rst_n = 1'b1;
    #1;
    chk("rel_busy", 32'(b8.disp_busy),   0);
    chk("rel_done", 32'(b8.disp_done),   0);
    chk("rel_rv",   32'(b8.disp_rvalid), 0);
    end_cyc();
    for (int i = 0; i < 8; i++) begin
      step_in(0, 0, 0, 0, 0, 13'h0000);
      chk($sformatf("nb%0d_rv", i),   32'(b8.disp_rvalid), 1);
      chk($sformatf("nb%0d_addr", i), 32'(b8.dm_addr),     32'(13'h0700 + 13'(i)));
      chk($sformatf("nb%0d_done", i), 32'(b8.disp_done),   0);
      end_cyc();
    end
    step_in(0, 0, 0, 0, 0, 13'h0000);
    chk("nb_done", 32'(b8.disp_done), 1);
    end_cyc();

    // BURST_LEN=4 instance: wrap from 0x1FFE
    @(posedge clk);
    #1;
    b4.disp_req  = 1'b1;
    b4.disp_base = 13'h1FFE;
    @(posedge clk);
    #1;
    b4.disp_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [12:0] wa;
      wa = 13'h1FFE + 13'(i);
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      #1;
      chk($sformatf("w%0d_rv", i),   32'(b4.disp_rvalid), 1);
      chk($sformatf("w%0d_addr", i), 32'(b4.dm_addr),     32'(wa));
      @(negedge clk);
      #1;
      chk($sformatf("w%0d_rd", i),   32'(b4.disp_rdata),  32'(pat(wa)));
    end
    @(posedge clk);
    #2;
    chk("w_done", 32'(b4.disp_done), 1);
    chk("w_busy", 32'(b4.disp_busy), 0);
    @(posedge clk);
    #2;
    chk("w_done_pulse", 32'(b4.disp_done), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout: got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning:
- BURST_LEN, 8, display words per burst (legal 1..256).
- STARVE_LIM, 3, consecutive burst cycles the CPU may win before the display is forced (legal >=1).

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning:
- clk, in, 1, single clock; memory acts on negedge.
- rst_n, in, 1, asynchronous active-low reset.
- cpu_addr, in, 13, CPU word address.
- cpu_re, in, 1, CPU read request.
- cpu_we, in, 1, CPU write request.
- cpu_wdata, in, 16, CPU write data.
- cpu_gnt, out, 1, CPU access performed this cycle.
- cpu_stall, out, 1, CPU request pending, not granted.
- cpu_rdata, out, 16, read data, valid at end of a granted read cycle.
- disp_req, in, 1, display burst request.
- disp_base, in, 13, burst start address.
- disp_busy, out, 1, burst in progress.
- disp_rvalid, out, 1, display beat issued this cycle.
- disp_rdata, out, 16, beat data, valid at end of rvalid cycle.
- disp_done, out, 1, one-cycle pulse after the final beat.
- dm_addr, out, 13, memory address.
- dm_re, out, 1, memory read enable.
- dm_we, out, 1, memory write enable.
- dm_wdata, out, 16, memory write data.
- dm_rd_data, in, 16, memory read data.

Function
REQ-003 The block SHALL have two states: IDLE and BURST.
REQ-004 Each cycle SHALL have exactly one winner (CPU, display or none), decided combinationally from the current requests and registered state; dm_* SHALL be driven combinationally from the winner so the access completes at that cycle's negedge.
REQ-005 A CPU request SHALL be cpu_re|cpu_we; if both are high, the write SHALL take precedence and dm_re SHALL be 0.
REQ-006 dm_re and dm_we SHALL never be high in the same cycle; with no winner, both SHALL be 0, dm_addr SHALL be 0 and dm_wdata SHALL be 0.
REQ-007 In IDLE, a CPU request SHALL always win.
REQ-008 In IDLE, disp_req high at a posedge SHALL latch disp_base into the burst address, clear the beat count and enter BURST; disp_busy SHALL be a registered output, high throughout BURST.
REQ-009 In BURST, the display SHALL win if there is no CPU request or if starve_cnt==STARVE_LIM; otherwise the CPU SHALL win.
REQ-010 starve_cnt SHALL increment on each BURST cycle the CPU wins, SHALL clear on each display win, and SHALL be 0 in IDLE.
REQ-011 A display win SHALL produce dm_re=1, dm_addr=burst address and disp_rvalid=1; at the closing posedge, the burst address SHALL increment modulo 8192 (8191 wraps to 0) and the beat count SHALL increment.
REQ-012 The closing posedge of beat BURST_LEN SHALL return the block to IDLE and assert disp_done for exactly the following cycle.
REQ-013 disp_req SHALL be ignored while disp_busy=1.
REQ-014 disp_req held high SHALL start a new burst at the posedge ending the disp_done cycle.
REQ-015 The next burst SHALL use the disp_base value sampled at that posedge.
REQ-016 cpu_gnt SHALL equal the CPU win.
REQ-017 cpu_stall SHALL equal a CPU request that does not win.
REQ-018 cpu_rdata and disp_rdata SHALL both pass dm_rd_data through unmodified.
REQ-019 Zero-latency requirement: a granted CPU read issued in cycle N SHALL return its data, sampled at the posedge ending cycle N.

Reset
REQ-020 rst_n low SHALL asynchronously force IDLE, burst address 0, beat count 0 and starve_cnt 0, and SHALL force disp_busy=0 and disp_done=0.
REQ-021 While rst_n is low, cpu_gnt, cpu_stall, disp_rvalid, dm_re and dm_we SHALL be 0.
REQ-022 A reset mid-burst SHALL abandon the burst with no disp_done; the first posedge after release SHALL behave as IDLE.

Verification
REQ-023 CPU write 0x1234 to 0x0040, then read 0x0040 -> cpu_gnt=1 on both cycles, cpu_stall=0, cpu_rdata=0x1234 at end of the read cycle.
REQ-024 disp_req with disp_base=0x0100, no CPU traffic -> 8 consecutive disp_rvalid beats at 0x0100..0x0107, then disp_done for one cycle, then disp_busy=0.
REQ-025 Burst from 0x1FFE with BURST_LEN=4 -> beat addresses 0x1FFE, 0x1FFF, 0x0000, 0x0001.
REQ-026 CPU reads on every cycle during a burst, STARVE_LIM=3 -> repeating pattern of 3 CPU wins then 1 display beat, with cpu_stall=1 only on display cycles; the burst completes in 32 cycles.
REQ-027 cpu_re=cpu_we=1 -> dm_we=1, dm_re=0, write performed; a second disp_req mid-burst -> ignored, single disp_done.
REQ-028 rst_n low after beat 3 -> all outputs 0 immediately with no disp_done; after release, a fresh disp_req restarts at the new base.
